mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage between EXE and WB. Latches the EXE->MEM bus and takes read data from the synchronous data SRAM.
//  Aligns and extends LD.B/BU/H/HU/W data and passes exception/CSR/ertn info to WB.
//  Drives a MEM forward bus to ID and buffers SRAM rdata while WB stalls, since the SRAM drives it for one cycle only.
// PARAMETERS
//  ES_TO_MS_WD  170  EXE->MEM bus width (layout below)
//  MS_TO_WS_WD  192  MEM->WB bus width (layout below)
//  MS_FWD_WD    57   forward bus width
// PORTS
//  clk              in   1    clock; everything on posedge
//  resetn           in   1    synchronous, active-low reset
//  final_ex         in   1    exception committed in WB: flush stage
//  back_ertn_flush  in   1    ertn committed in WB: flush stage
//  ws_allowin       in   1    WB can accept
//  ms_allowin       out  1    MEM can accept
//  es_to_ms_valid   in   1    EXE offers an instruction
//  es_to_ms_bus     in   170  [169]rdcntid [168]ertn [167]esubcode [166:161]ecode [160]ex [159]csr_re [158:145]csr_num
//                             [144:113]csr_wvalue [112:81]csr_wmask [80]csr_we [79:78]addr_lo [77:73]ld_w,b,bu,h,hu
//                             [72:71]st_b,h [70]res_from_mem [69]gr_we [68:64]dest [63:32]result [31:0]pc
//  data_sram_rdata  in   32   SRAM read data, valid the cycle after the EXE request
//  ms_to_ws_valid   out  1    MEM offers an instruction to WB
//  ms_to_ws_bus     out  192  [191:160]vaddr [159]rdcntid [158]ertn [157]esubcode [156:151]ecode [150]ex [149]csr_re
//                             [148:135]csr_num [134:103]csr_wvalue [102:71]csr_wmask [70]csr_we [69]gr_we
//                             [68:64]dest [63:32]final_result [31:0]pc
//  ms_forward       out  57   [56]csr_re [55:42]csr_num [41]csr_we [40]ertn [39]ex [38:7]final_result [6:2]dest [1]gr_we [0]valid
//  ms_ex            out  1    ms_valid & bus ex: EXE suppresses SRAM access
//  ms_ertn_flush    out  1    ms_valid & bus ertn
// BEHAVIOUR
//  - Reset: ms_valid=0, buf_valid=0, first=0. All outputs then 0 except ms_allowin=1.
//  - ms_ready_go=1. ms_allowin = !ms_valid | ws_allowin. ms_to_ws_valid = ms_valid & ~final_ex.
//  - ms_valid: cleared on !resetn | final_ex | back_ertn_flush (these take priority); else if ms_allowin, <= es_to_ms_valid.
//  - Bus register loads when es_to_ms_valid & ms_allowin. It holds during a stall.
//  - first flag = 1 in the cycle a new instruction is latched, 0 afterwards.
//    That cycle is the only one where data_sram_rdata belongs to this instruction.
//  - Read buffer: if ms_valid & first & res_from_mem & !ws_allowin, capture rdata_buf<=data_sram_rdata and set buf_valid=1.
//    Clear buf_valid when the instruction leaves (ws_allowin) or on reset/flush.
//    mem_word = buf_valid ? rdata_buf : data_sram_rdata.
//  - Load select:
//    - byte = mem_word[8*addr_lo+:8]; half = addr_lo[1] ? [31:16] : [15:0].
//    - ld_b sign-extends byte, ld_bu zero-extends byte, ld_h/ld_hu sign/zero-extend half, ld_w uses the word.
//    - Misaligned loads never reach here with res_from_mem=1, because EXE clears it on ALE.
//  - final_result = res_from_mem ? load_data : result. vaddr = result (BADV source for ALE).
//  - gr_we forwarded/sent = gr_we & ~ex.
//  - ms_to_ws_bus and ms_forward payload are ANDed with ms_valid, so they are all-zero when empty.
//  - Flush and stall in the same cycle: the flush wins; ms_valid=0 and buf_valid=0 next cycle.
//  - Back-to-back loads with WB ready: the buffer is never used, giving one load per cycle.
// TESTING
//  - ld.b addr_lo=2'b11, rdata=32'h80FF_1234, ws_allowin=1 -> final_result=32'hFFFF_FF80, same cycle.
//  - ld.hu addr_lo=2'b10, rdata=32'hBEEF_0001 -> final_result=32'h0000_BEEF. ld.h -> 32'hFFFF_BEEF.
//  - ld.w with ws_allowin=0 for 3 cycles; rdata=32'h1234_5678 in the first cycle, then garbage
//    -> on release, final_result=32'h1234_5678 and ms_to_ws_valid=1 throughout.
//  - Bus ex=1, ecode=ALE, gr_we=1 -> ms_ex=1, sent gr_we=0, vaddr=result, forward[39]=1.
//  - final_ex pulse while valid & stalled -> next cycle ms_valid=0, ms_to_ws_valid=0, bus=0, buf_valid=0.
//  - resetn=0 mid-stall -> next cycle ms_allowin=1 and all outputs 0. The first es_to_ms_valid after reset is latched normally.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EXE->MEM bus, aligns and extends SRAM load
// data, and hands the instruction to WB. It also drives the MEM forward bus
// to ID and holds SRAM read data for as long as WB stalls.
//
// Handshake (valid/ready): a transfer from EXE happens on a rising clk edge
// where es_to_ms_valid && ms_allowin. A transfer to WB happens where
// ms_to_ws_valid && ws_allowin. A holder of valid keeps its payload stable
// until the transfer takes place. A WB flush (final_ex / back_ertn_flush)
// drops whatever this stage holds, regardless of the handshake.
module mem_stage #(
  parameter int ES_TO_MS_WD = 170,
  parameter int MS_TO_WS_WD = 192,
  parameter int MS_FWD_WD   = 57
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   final_ex,
  input  logic                   back_ertn_flush,
  input  logic                   ws_allowin,
  output logic                   ms_allowin,
  input  logic                   es_to_ms_valid,
  input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]            data_sram_rdata,
  output logic                   ms_to_ws_valid,
  output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
  output logic [MS_FWD_WD-1:0]   ms_forward,
  output logic                   ms_ex,
  output logic                   ms_ertn_flush
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                   ms_valid_q,  ms_valid_d;
  logic [ES_TO_MS_WD-1:0] bus_q,       bus_d;
  logic                   first_q,     first_d;
  logic                   buf_valid_q, buf_valid_d;
  logic [31:0]            rdata_buf_q, rdata_buf_d;

  logic ms_ready_go;
  logic flush;
  logic accept;

  // ---------------------------------------------------------------------------
  // Fields of the latched EXE->MEM bus
  // ---------------------------------------------------------------------------
  logic        f_rdcntid;
  logic        f_ertn;
  logic        f_esubcode;
  logic [5:0]  f_ecode;
  logic        f_ex;
  logic        f_csr_re;
  logic [13:0] f_csr_num;
  logic [31:0] f_csr_wvalue;
  logic [31:0] f_csr_wmask;
  logic        f_csr_we;
  logic [1:0]  f_addr_lo;
  logic        f_ld_w;
  logic        f_ld_b;
  logic        f_ld_bu;
  logic        f_ld_h;
  logic        f_ld_hu;
  logic        f_res_from_mem;
  logic        f_gr_we;
  logic [4:0]  f_dest;
  logic [31:0] f_result;
  logic [31:0] f_pc;

  // Store-size bits travel on the bus for EXE's benefit only.
  logic unused_st;

  assign f_rdcntid      = bus_q[169];
  assign f_ertn         = bus_q[168];
  assign f_esubcode     = bus_q[167];
  assign f_ecode        = bus_q[166:161];
  assign f_ex           = bus_q[160];
  assign f_csr_re       = bus_q[159];
  assign f_csr_num      = bus_q[158:145];
  assign f_csr_wvalue   = bus_q[144:113];
  assign f_csr_wmask    = bus_q[112:81];
  assign f_csr_we       = bus_q[80];
  assign f_addr_lo      = bus_q[79:78];
  assign f_ld_w         = bus_q[77];
  assign f_ld_b         = bus_q[76];
  assign f_ld_bu        = bus_q[75];
  assign f_ld_h         = bus_q[74];
  assign f_ld_hu        = bus_q[73];
  assign unused_st      = ^bus_q[72:71];
  assign f_res_from_mem = bus_q[70];
  assign f_gr_we        = bus_q[69];
  assign f_dest         = bus_q[68:64];
  assign f_result       = bus_q[63:32];
  assign f_pc           = bus_q[31:0];

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign ms_ready_go    = 1'b1;
  assign flush          = final_ex | back_ertn_flush;
  assign ms_allowin     = !ms_valid_q | (ms_ready_go & ws_allowin);
  assign accept         = es_to_ms_valid & ms_allowin;
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~final_ex;

  // Next-state for the valid flag, bus register, first flag and read buffer.
  always_comb begin
    ms_valid_d  = ms_valid_q;
    bus_d       = bus_q;
    first_d     = 1'b0;
    buf_valid_d = buf_valid_q;
    rdata_buf_d = rdata_buf_q;

    // A flush beats any incoming instruction.
    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end

    // The bus only moves on a real transfer, so it holds through stalls.
    if (accept) begin
      bus_d = es_to_ms_bus;
    end

    // SRAM rdata belongs to this instruction only in its first cycle here.
    first_d = accept & ~flush;

    // Keep the SRAM word if WB is not taking the load in its data cycle.
    if (flush) begin
      buf_valid_d = 1'b0;
    end else if (ws_allowin) begin
      buf_valid_d = 1'b0;
    end else if (ms_valid_q && first_q && f_res_from_mem) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q  <= 1'b0;
      bus_q       <= '0;
      first_q     <= 1'b0;
      buf_valid_q <= 1'b0;
      rdata_buf_q <= '0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      bus_q       <= bus_d;
      first_q     <= first_d;
      buf_valid_q <= buf_valid_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  logic [31:0] mem_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        gr_we_out;

  assign mem_word = buf_valid_q ? rdata_buf_q : data_sram_rdata;

  // Pick the addressed byte and halfword out of the memory word.
  always_comb begin
    byte_sel = mem_word[7:0];
    case (f_addr_lo)
      2'd0:    byte_sel = mem_word[7:0];
      2'd1:    byte_sel = mem_word[15:8];
      2'd2:    byte_sel = mem_word[23:16];
      default: byte_sel = mem_word[31:24];
    endcase
    half_sel = f_addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
  end

  // One-hot load type selects the sign/zero-extended value.
  always_comb begin
    load_data = ({32{f_ld_w}}  & mem_word)
              | ({32{f_ld_b}}  & {{24{byte_sel[7]}}, byte_sel})
              | ({32{f_ld_bu}} & {24'd0, byte_sel})
              | ({32{f_ld_h}}  & {{16{half_sel[15]}}, half_sel})
              | ({32{f_ld_hu}} & {16'd0, half_sel});
    final_result = f_res_from_mem ? load_data : f_result;
  end

  // A faulting instruction must not write the register file.
  assign gr_we_out = f_gr_we & ~f_ex;

  // ---------------------------------------------------------------------------
  // Outputs: payloads read as all-zero while the stage is empty
  // ---------------------------------------------------------------------------
  assign ms_to_ws_bus = {MS_TO_WS_WD{ms_valid_q}} & {
    f_result,          // [191:160] vaddr (BADV source for ALE)
    f_rdcntid,         // [159]
    f_ertn,            // [158]
    f_esubcode,        // [157]
    f_ecode,           // [156:151]
    f_ex,              // [150]
    f_csr_re,          // [149]
    f_csr_num,         // [148:135]
    f_csr_wvalue,      // [134:103]
    f_csr_wmask,       // [102:71]
    f_csr_we,          // [70]
    gr_we_out,         // [69]
    f_dest,            // [68:64]
    final_result,      // [63:32]
    f_pc               // [31:0]
  };

  assign ms_forward = {MS_FWD_WD{ms_valid_q}} & {
    f_csr_re,          // [56]
    f_csr_num,         // [55:42]
    f_csr_we,          // [41]
    f_ertn,            // [40]
    f_ex,              // [39]
    final_result,      // [38:7]
    f_dest,            // [6:2]
    gr_we_out,         // [1]
    ms_valid_q         // [0]
  };

  assign ms_ex         = ms_valid_q & f_ex;
  assign ms_ertn_flush = ms_valid_q & f_ertn;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed load/stall/flush/reset scenarios followed
// by randomized traffic, all checked against a transaction-level model.
module tb_mem_stage;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic         final_ex;
  logic         back_ertn_flush;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [169:0] es_to_ms_bus;
  logic [31:0]  data_sram_rdata;
  logic         ms_to_ws_valid;
  logic [191:0] ms_to_ws_bus;
  logic [56:0]  ms_forward;
  logic         ms_ex;
  logic         ms_ertn_flush;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .final_ex        (final_ex),
    .back_ertn_flush (back_ertn_flush),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .ms_forward      (ms_forward),
    .ms_ex           (ms_ex),
    .ms_ertn_flush   (ms_ertn_flush)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the instruction held in MEM and the memory word it
  // was given (whatever the SRAM presented during its first cycle here).
  logic         m_valid;
  logic [169:0] m_bus;
  logic         m_have_word;
  logic [31:0]  m_word;

  // Outputs sampled at the last negedge, for directed checks.
  logic [191:0] s_bus;
  logic [56:0]  s_fwd;
  logic         s_tv;
  logic         s_allow;
  logic         s_ex;
  logic         s_ertn;

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural load result from the bus fields and the memory word.
  function automatic logic [31:0] ref_result(input logic [169:0] b, input logic [31:0] w);
    int          a;
    logic [31:0] bytev;
    logic [31:0] halfv;
    a     = int'(b[79:78]);
    bytev = (w >> (8 * a)) & 32'h0000_00FF;
    halfv = (w >> (16 * (a / 2))) & 32'h0000_FFFF;
    if (!b[70]) return b[63:32];
    if (b[77]) return w;
    if (b[76]) return (bytev >= 32'd128) ? (bytev | 32'hFFFF_FF00) : bytev;
    if (b[75]) return bytev;
    if (b[74]) return (halfv >= 32'h8000) ? (halfv | 32'hFFFF_0000) : halfv;
    return halfv;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle of stimulus, checked at negedge, model stepped at posedge
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic rstn, input logic esv, input logic [169:0] bus,
                       input logic [31:0] rdata, input logic wsa, input logic fex,
                       input logic ertnf);
    logic [31:0]  word;
    logic [31:0]  fr;
    logic         gw;
    logic [191:0] exp_bus;
    logic [56:0]  exp_fwd;

    resetn          = rstn;
    es_to_ms_valid  = esv;
    es_to_ms_bus    = bus;
    data_sram_rdata = rdata;
    ws_allowin      = wsa;
    final_ex        = fex;
    back_ertn_flush = ertnf;

    @(negedge clk);
    s_bus   = ms_to_ws_bus;
    s_fwd   = ms_forward;
    s_tv    = ms_to_ws_valid;
    s_allow = ms_allowin;
    s_ex    = ms_ex;
    s_ertn  = ms_ertn_flush;

    word = m_have_word ? m_word : data_sram_rdata;
    fr   = ref_result(m_bus, word);
    gw   = m_bus[69] & ~m_bus[160];
    exp_bus = '0;
    exp_fwd = '0;
    if (m_valid) begin
      exp_bus = {m_bus[63:32], m_bus[169:160], m_bus[159:80], gw, m_bus[68:64], fr, m_bus[31:0]};
      exp_fwd = {m_bus[159], m_bus[158:145], m_bus[80], m_bus[168], m_bus[160], fr,
                 m_bus[68:64], gw, 1'b1};
    end
    check_eq("allowin",  192'(s_allow), 192'(!m_valid || ws_allowin));
    check_eq("to_ws_v",  192'(s_tv),    192'(m_valid && !final_ex));
    check_eq("ws_bus",   s_bus,         exp_bus);
    check_eq("forward",  192'(s_fwd),   192'(exp_fwd));
    check_eq("ms_ex",    192'(s_ex),    192'(m_valid && m_bus[160]));
    check_eq("ms_ertn",  192'(s_ertn),  192'(m_valid && m_bus[168]));

    @(posedge clk);
    if (m_valid && !m_have_word) begin
      m_word      = data_sram_rdata;
      m_have_word = 1'b1;
    end
    if (!resetn || final_ex || back_ertn_flush) begin
      m_valid = 1'b0;
    end else if (!m_valid || ws_allowin) begin
      m_valid = es_to_ms_valid;
      if (es_to_ms_valid) begin
        m_bus       = es_to_ms_bus;
        m_have_word = 1'b0;
      end
    end
    #1;
  endtask

  // Aligned load with recognisable non-load fields; ld = {w,b,bu,h,hu}.
  function automatic logic [169:0] mk_load(input logic [4:0] ld, input logic [1:0] a);
    logic [169:0] b;
    b          = '0;
    b[77:73]   = ld;
    b[79:78]   = a;
    b[70]      = 1'b1;
    b[69]      = 1'b1;
    b[68:64]   = 5'd7;
    b[63:32]   = 32'h1C00_0100 + 32'(a);
    b[31:0]    = 32'h1C00_0000;
    return b;
  endfunction

  // Random EXE bus; misaligned loads arrive as ALE with res_from_mem cleared.
  function automatic logic [169:0] rand_bus();
    logic [169:0] b;
    logic [1:0]   a;
    for (int i = 0; i < 170; i++) b[i] = 1'($urandom_range(0, 1));
    b[77:73] = 5'b10000 >> $urandom_range(0, 4);
    b[70]    = ($urandom_range(0, 2) != 0);
    b[160]   = ($urandom_range(0, 7) == 0);
    b[168]   = ($urandom_range(0, 7) == 0);
    a        = b[79:78];
    if (b[70] && ((b[77] && a != 2'd0) || ((b[74] || b[73]) && a[0]))) begin
      b[70]      = 1'b0;
      b[160]     = 1'b1;
      b[166:161] = 6'h09;
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [169:0] b;

    resetn = 1'b0; final_ex = 1'b0; back_ertn_flush = 1'b0; ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0; es_to_ms_bus = '0; data_sram_rdata = '0;
    m_valid = 1'b0; m_bus = '0; m_have_word = 1'b0; m_word = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    cycle(1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("reset_allowin", 192'(s_allow), 192'(1'b1));
    check_eq("reset_bus",     s_bus,         192'd0);

    // ld.b at byte 3, then ld.hu and ld.h back to back
    cycle(1'b1, 1'b1, mk_load(5'b01000, 2'b11), 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, mk_load(5'b00001, 2'b10), 32'h80FF_1234, 1'b1, 1'b0, 1'b0);
    check_eq("ld_b", 192'(s_bus[63:32]), 192'(32'hFFFF_FF80));
    cycle(1'b1, 1'b1, mk_load(5'b00010, 2'b10), 32'hBEEF_0001, 1'b1, 1'b0, 1'b0);
    check_eq("ld_hu", 192'(s_bus[63:32]), 192'(32'h0000_BEEF));
    cycle(1'b1, 1'b0, '0, 32'hBEEF_0001, 1'b1, 1'b0, 1'b0);
    check_eq("ld_h", 192'(s_bus[63:32]), 192'(32'hFFFF_BEEF));

    // ld.w held by WB for three cycles with garbage after the data cycle
    cycle(1'b1, 1'b1, mk_load(5'b10000, 2'b00), 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    check_eq("stall_v0", 192'(s_tv), 192'(1'b1));
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, '0, $urandom, 1'b0, 1'b0, 1'b0);
      check_eq("stall_v", 192'(s_tv), 192'(1'b1));
    end
    cycle(1'b1, 1'b0, '0, $urandom, 1'b1, 1'b0, 1'b0);
    check_eq("stall_release", 192'(s_bus[63:32]), 192'(32'h1234_5678));

    // Address-error exception
    b = mk_load(5'b10000, 2'b01);
    b[70] = 1'b0; b[160] = 1'b1; b[166:161] = 6'h09;
    cycle(1'b1, 1'b1, b, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0);
    check_eq("ale_ms_ex", 192'(s_ex),            192'(1'b1));
    check_eq("ale_gr_we", 192'(s_bus[69]),       192'(1'b0));
    check_eq("ale_vaddr", 192'(s_bus[191:160]),  192'(32'h1C00_0101));
    check_eq("ale_fwd",   192'(s_fwd[39]),       192'(1'b1));

    // final_ex while valid and stalled; buffer must not leak into the next load
    cycle(1'b1, 1'b1, mk_load(5'b10000, 2'b00), 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 32'h0BAD_0BAD, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_eq("flush_tv_same", 192'(s_tv), 192'(1'b0));
    cycle(1'b1, 1'b0, '0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("flush_tv",    192'(s_tv),    192'(1'b0));
    check_eq("flush_bus",   s_bus,         192'd0);
    check_eq("flush_allow", 192'(s_allow), 192'(1'b1));
    cycle(1'b1, 1'b1, mk_load(5'b10000, 2'b00), 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
    check_eq("post_flush_ld", 192'(s_bus[63:32]), 192'(32'hCAFE_F00D));

    // Reset in the middle of a stall
    cycle(1'b1, 1'b1, mk_load(5'b10000, 2'b00), 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 32'h7777_7777, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_allow", 192'(s_allow), 192'(1'b1));
    check_eq("rst_bus",   s_bus,         192'd0);
    check_eq("rst_fwd",   192'(s_fwd),   192'd0);
    cycle(1'b1, 1'b1, mk_load(5'b01000, 2'b00), 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 32'h0000_0042, 1'b1, 1'b0, 1'b0);
    check_eq("rst_relatch", 192'(s_bus[63:32]), 192'(32'h0000_0042));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 49) != 0),
            1'($urandom_range(0, 3) != 0),
            rand_bus(),
            $urandom,
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 29) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
